// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matvec_pkg
// Brief    : Shared state type and sizing helpers for the matrix-vector engine.
// Revision : 1.0
// ============================================================================
package matvec_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Accumulator wide enough that one full dot product can never wrap.
    function automatic int default_acc_width(input int data_width, input int cols);
        return 2 * data_width + $clog2(cols);
    endfunction

    // Width of a counter/index covering n values, never below one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_mac.sv
`default_nettype none
// ============================================================================
// Module   : matvec_mac
// Brief    : One systolic processing element: multiply-accumulate with a
//            registered pass-through of the B operand and enable.
// Revision : 1.0
// ============================================================================
module matvec_mac #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 19,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_in,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  en_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic [ACC_WIDTH-1:0]  acc
);

    localparam int c_PROD_W = 2 * DATA_WIDTH;

    logic [ACC_WIDTH-1:0] w_prod_ext;

    generate
        if (SIGNED) begin : g_signed
            logic signed [c_PROD_W-1:0] w_prod;
            assign w_prod     = c_PROD_W'($signed(a_in)) * c_PROD_W'($signed(b_in));
            assign w_prod_ext = ACC_WIDTH'(w_prod);
        end else begin : g_unsigned
            logic [c_PROD_W-1:0] w_prod;
            assign w_prod     = c_PROD_W'(a_in) * c_PROD_W'(b_in);
            assign w_prod_ext = ACC_WIDTH'(w_prod);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_out <= 1'b0;
            b_out  <= '0;
            acc    <= '0;
        end else begin
            en_out <= en_in;
            b_out  <= b_in;
            if (clr) begin
                acc <= '0;
            end else if (en_in) begin
                acc <= acc + w_prod_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/matvec_engine.sv
`default_nettype none
// ============================================================================
// Module   : matvec_engine
// Brief    : C = A*B for a ROWS x COLS matrix and COLS vector using a skewed
//            chain of MAC elements, with valid/ready input and output streams.
// Revision : 1.0
// ============================================================================
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter bit SIGNED     = 1'b0,
    parameter int ACC_WIDTH  = default_acc_width(DATA_WIDTH, COLS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        acc_keep,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_data,
    output logic [cnt_width(ROWS)-1:0]  out_idx,
    output logic                        busy,
    output logic                        done
);

    localparam int c_IDX_W  = cnt_width(ROWS);
    localparam int c_COL_W  = cnt_width(COLS);
    localparam int c_CALC_W = cnt_width(ROWS + COLS - 1);

    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(ROWS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE   = c_IDX_W'(1);
    localparam logic [c_COL_W-1:0]  c_COL_LAST  = c_COL_W'(COLS - 1);
    localparam logic [c_COL_W-1:0]  c_COL_ONE   = c_COL_W'(1);
    localparam logic [c_CALC_W-1:0] c_CALC_LAST = c_CALC_W'(ROWS + COLS - 2);
    localparam logic [c_CALC_W-1:0] c_CALC_ONE  = c_CALC_W'(1);
    localparam logic [c_CALC_W:0]   c_COLS_EXT  = (c_CALC_W + 1)'(COLS);

    state_t r_state;
    state_t w_state_nxt;

    logic [c_IDX_W-1:0]  r_ld_row;
    logic [c_COL_W-1:0]  r_ld_col;
    logic                r_ld_b;
    logic [c_CALC_W-1:0] r_calc_cnt;
    logic [c_IDX_W-1:0]  r_out_idx;

    logic [DATA_WIDTH-1:0] r_a_buf [ROWS][COLS];
    logic [DATA_WIDTH-1:0] r_b_buf [COLS];

    logic                  w_in_fire;
    logic                  w_last_word;
    logic                  w_calc_end;
    logic                  w_last_idx;
    logic                  w_clr;
    logic                  w_en   [ROWS+1];
    logic [DATA_WIDTH-1:0] w_b    [ROWS+1];
    logic [ACC_WIDTH-1:0]  w_acc  [ROWS];
    logic                  w_unused_tail;

    assign w_in_fire   = in_valid && in_ready;
    assign w_last_word = r_ld_b && (r_ld_col == c_COL_LAST);
    assign w_calc_end  = (r_calc_cnt == c_CALC_LAST);
    assign w_last_idx  = (r_out_idx == c_IDX_LAST);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && w_last_word) begin
                    w_state_nxt = ST_CALC;
                    w_clr       = !acc_keep;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (w_calc_end) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready && w_last_idx) begin
                    done        = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // Load address: row/column walk through A, then a column walk through B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_row <= '0;
            r_ld_col <= '0;
            r_ld_b   <= 1'b0;
        end else if (w_in_fire) begin
            if (r_ld_col == c_COL_LAST) begin
                r_ld_col <= '0;
                if (r_ld_b) begin
                    r_ld_b <= 1'b0;
                end else if (r_ld_row == c_IDX_LAST) begin
                    r_ld_row <= '0;
                    r_ld_b   <= 1'b1;
                end else begin
                    r_ld_row <= r_ld_row + c_IDX_ONE;
                end
            end else begin
                r_ld_col <= r_ld_col + c_COL_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int k = 0; k < COLS; k++) begin
                    r_a_buf[r][k] <= '0;
                end
            end
            for (int k = 0; k < COLS; k++) begin
                r_b_buf[k] <= '0;
            end
        end else if (w_in_fire) begin
            if (r_ld_b) begin
                r_b_buf[r_ld_col] <= in_data;
            end else begin
                r_a_buf[r_ld_row][r_ld_col] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_calc_cnt <= '0;
            r_out_idx  <= '0;
        end else begin
            if (r_state == ST_CALC) begin
                r_calc_cnt <= w_calc_end ? '0 : r_calc_cnt + c_CALC_ONE;
            end
            if (r_state == ST_OUT && out_ready) begin
                r_out_idx <= w_last_idx ? '0 : r_out_idx + c_IDX_ONE;
            end
        end
    end

    // ------------------------------------------------------------ MAC chain
    // Element 0 is fed B[c]; element r sees it r cycles later, so it pairs
    // with A[r][c-r] taken from the row buffer at the same column offset.
    assign w_en[0] = (r_state == ST_CALC) && ({1'b0, r_calc_cnt} < c_COLS_EXT);
    assign w_b[0]  = r_b_buf[c_COL_W'(r_calc_cnt)];

    generate
        for (genvar i = 0; i < ROWS; i++) begin : g_mac
            logic [c_COL_W-1:0] w_k;
            assign w_k = c_COL_W'(r_calc_cnt - c_CALC_W'(i));

            matvec_mac #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SIGNED     (SIGNED)
            ) u_mac (
                .clk    (clk),
                .rst    (rst),
                .en_in  (w_en[i]),
                .clr    (w_clr),
                .a_in   (r_a_buf[i][w_k]),
                .b_in   (w_b[i]),
                .en_out (w_en[i+1]),
                .b_out  (w_b[i+1]),
                .acc    (w_acc[i])
            );
        end
    endgenerate

    assign w_unused_tail = w_en[ROWS] ^ (^w_b[ROWS]);

    assign out_idx  = r_out_idx;
    assign out_data = (r_state == ST_OUT) ? w_acc[r_out_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_matvec_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_matvec_engine
// Brief    : Self-checking bench for matvec_engine (unsigned and signed
//            instances driven in lockstep) against a dot-product model.
// Revision : 1.0
// ============================================================================
module tb_matvec_engine;

    localparam int     ROWS  = 8;
    localparam int     COLS  = 8;
    localparam int     ACC_W = 19;
    localparam longint MASK  = (longint'(1) << ACC_W) - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_keep = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        out_ready = 1'b0;

    logic              in_ready_u, out_valid_u, busy_u, done_u;
    logic [ACC_W-1:0]  out_data_u;
    logic [2:0]        out_idx_u;
    logic              in_ready_s, out_valid_s, busy_s, done_s;
    logic [ACC_W-1:0]  out_data_s;
    logic [2:0]        out_idx_s;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] a_m [ROWS][COLS];
    logic [7:0] b_v [COLS];
    longint     m_acc_u [ROWS];
    longint     m_acc_s [ROWS];

    always #5 clk = ~clk;

    matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(8), .SIGNED(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .acc_keep(acc_keep), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .out_valid(out_valid_u), .out_ready(out_ready), .out_data(out_data_u),
        .out_idx(out_idx_u), .busy(busy_u), .done(done_u)
    );

    matvec_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(8), .SIGNED(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .acc_keep(acc_keep), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_idx(out_idx_s), .busy(busy_s), .done(done_s)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    function automatic longint val(input logic [7:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    task automatic model_run(input bit keep);
        for (int r = 0; r < ROWS; r++) begin
            longint su = 0;
            longint ss = 0;
            for (int k = 0; k < COLS; k++) begin
                su += val(a_m[r][k], 1'b0) * val(b_v[k], 1'b0);
                ss += val(a_m[r][k], 1'b1) * val(b_v[k], 1'b1);
            end
            m_acc_u[r] = ((keep ? m_acc_u[r] : 0) + su) & MASK;
            m_acc_s[r] = ((keep ? m_acc_s[r] : 0) + ss) & MASK;
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++) begin
            m_acc_u[r] = 0;
            m_acc_s[r] = 0;
        end
    endtask

    // pat: 0 identity/B=1..8, 1 all 0xFF, 2 all 0x80, 3 A=-1/B=k+1, else random
    task automatic fill(input int pat);
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                case (pat)
                    0:       a_m[r][k] = (r == k) ? 8'd1 : 8'd0;
                    1:       a_m[r][k] = 8'hFF;
                    2:       a_m[r][k] = 8'h80;
                    3:       a_m[r][k] = 8'hFF;
                    default: a_m[r][k] = 8'($urandom);
                endcase
            end
        end
        for (int k = 0; k < COLS; k++) begin
            case (pat)
                0, 3:    b_v[k] = 8'(k + 1);
                1:       b_v[k] = 8'hFF;
                2:       b_v[k] = 8'h80;
                default: b_v[k] = 8'($urandom);
            endcase
        end
    endtask

    // ----------------------------------------------------------- drivers
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready_u, 1);
        chk("rst_out_valid", out_valid_u, 0);
        chk("rst_out_idx", out_idx_u, 0);
        chk("rst_busy", busy_u, 0);
        chk("rst_done", done_s, 0);
        chk("rst_out_data", out_data_s, 0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic load_run(input bit keep);
        acc_keep = keep;
        for (int w = 0; w < ROWS * COLS + COLS; w++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = (w < ROWS * COLS) ? a_m[w / COLS][w % COLS] : b_v[w - ROWS * COLS];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("in_ready_drop", in_ready_u, 0);
        chk("busy_rise", busy_s, 1);
    endtask

    task automatic wait_first_out(input int exp_lat);
        int n = 0;
        while (!out_valid_u && n < 50) begin
            chk("busy_calc", busy_u, 1);
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("first_out_latency", n, exp_lat);
        chk("out_valid_s_first", out_valid_s, 1);
    endtask

    // mode: 0 always ready, 1 random ready, 2 five-cycle stall at index 3
    task automatic drain(input int mode);
        int h = 0;
        int stall = 0;
        int guard = 0;
        logic rdy;
        while (h < ROWS && guard < 300) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: begin
                    rdy = !(h == 3 && stall < 5);
                    if (!rdy) stall++;
                end
            endcase
            out_ready = rdy;
            #1;
            chk("out_valid", out_valid_u, 1);
            chk("out_idx_u", out_idx_u, h);
            chk("out_idx_s", out_idx_s, h);
            chk("out_data_u", out_data_u, m_acc_u[h]);
            chk("out_data_s", out_data_s, m_acc_s[h]);
            chk("done", done_u, (rdy && h == ROWS - 1) ? 1 : 0);
            @(posedge clk); #1;
            if (rdy) h++;
            guard++;
        end
        out_ready = 1'b0;
        chk("drain_count", h, ROWS);
        chk("in_ready_after_done", in_ready_u, 1);
        chk("out_valid_after_done", out_valid_s, 0);
    endtask

    task automatic run(input int pat, input bit keep, input int mode);
        fill(pat);
        load_run(keep);
        model_run(keep);
        wait_first_out(ROWS + COLS - 1);
        drain(mode);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        run(0, 1'b0, 0);  // identity
        run(1, 1'b0, 1);  // all 0xFF
        run(2, 1'b0, 0);  // all 0x80
        run(3, 1'b0, 1);  // -1 row times 1..8
        run(4, 1'b0, 2);  // backpressure at index 3

        // accumulate across runs
        run(0, 1'b0, 0);
        run(0, 1'b1, 1);
        run(0, 1'b0, 0);

        // reset in the middle of CALC, then accumulate onto what must be zero
        fill(4);
        load_run(1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midcalc_rst_in_ready", in_ready_u, 1);
        chk("midcalc_rst_busy", busy_s, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        run(0, 1'b1, 0);

        // partial load aborted by reset
        fill(4);
        for (int w = 0; w < 10; w++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        do_reset();
        run(4, 1'b0, 1);

        for (int i = 0; i < 6; i++) begin
            run(4, 1'($urandom), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matvec_engine.md
# matvec_engine

Parametrised matrix–vector multiply engine: it computes C = A·B for a ROWS×COLS matrix A and a COLS-element vector B. Operands arrive on one valid/ready input stream and are held in on-chip row buffers. A skewed systolic chain of ROWS multiply-accumulate elements does the arithmetic. The ROWS results leave on a valid/ready output stream. It sits between the memory/load front end and the result display/consumer logic, and is the next-generation, parametrised compute core of the matrix datapath.

## Interface
- ROWS, 8, number of rows of A, which is also the number of MAC elements and results (≥1)
- COLS, 8, number of columns of A and length of B (≥1)
- DATA_WIDTH, 8, width of each A and B element
- SIGNED, 0, 1 means operands and results are two's complement; 0 means unsigned
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(COLS), accumulator and result width
- clk  input  1  clock; all logic is rising-edge
- rst  input  1  reset, asynchronous, active-high
- acc_keep  input  1  sampled on the LOAD→CALC transition; 1 skips the accumulator clear
- in_valid  input  1  in_data is valid
- in_ready  output  1  engine accepts in_data this cycle
- in_data  input  DATA_WIDTH  operand word
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  ACC_WIDTH  result C[out_idx]
- out_idx  output  $clog2(ROWS) (min 1)  row index of out_data
- busy  output  1  high in CALC
- done  output  1  one-cycle pulse when the last result is accepted

## Operation
- The state machine has three states: LOAD, CALC and OUT. Reset state is LOAD.
- LOAD:
  - in_ready=1. A word transfers when in_valid&&in_ready.
  - Word order is A row-major (A[0][0..COLS-1], A[1][…], …), then B[0..COLS-1]. That is ROWS*COLS+COLS words in total.
  - A load counter selects the destination buffer. After the last word it goes to CALC.
- CALC, which lasts exactly ROWS+COLS-1 cycles, cycle counter c=0..ROWS+COLS-2:
  - MAC r is enabled iff r ≤ c < r+COLS. When enabled it adds A[r][c-r]*B[c-r] into acc[r].
  - B and the enable propagate down the chain through one register per element, so MAC r+1 sees them one cycle after MAC r.
  - The accumulators clear on entry unless acc_keep=1.
- OUT:
  - out_valid=1, with out_data=acc[out_idx] and out_idx starting at 0.
  - out_idx increments on each out_valid&&out_ready.
  - On the handshake with out_idx=ROWS-1: done=1 for that cycle and the state goes to LOAD.
- Arithmetic:
  - The product is 2*DATA_WIDTH bits. It is sign- or zero-extended per SIGNED to ACC_WIDTH.
  - The accumulator wraps modulo 2^ACC_WIDTH; no saturation.
  - With the default ACC_WIDTH a single run cannot overflow. Overflow is possible only with acc_keep.
- Buffers hold their contents across runs. They are rewritten only by LOAD.

## Timing
- Reset values: in_ready=1, out_valid=0, out_idx=0, busy=0, done=0, out_data=0. All accumulators, buffers and counters are 0.
- Reset asserted mid-LOAD, mid-CALC or mid-OUT aborts immediately. Partial loads are discarded and no done is issued.
- in_ready falls in the cycle after the last load handshake, which is the first cycle of CALC.
- LOAD→first out_valid latency: ROWS+COLS-1 cycles after the last load word. Default is 15.
- out_valid and out_data stay stable while out_ready=0, with unlimited stall. in_valid is ignored outside LOAD.
- A new LOAD can accept its first word in the cycle after done.

## Structure
- Package matvec_pkg holds:
  - the state enum (LOAD, CALC, OUT)
  - a function computing the default ACC_WIDTH
  - a function for the load-counter width
- Sub-module matvec_mac is one processing element with parameters DATA_WIDTH, ACC_WIDTH and SIGNED. Ports:
  - clk, rst
  - en_in, clr, a_in, b_in
  - en_out, b_out (registered pass-through)
  - acc
- The top instantiates ROWS copies of matvec_mac in a chain, plus the A/B buffers, the counters and the state machine.

## Test plan
- Identity test, default params: A=I, B=1..8 → results 1..8, out_idx 0..7, done on the 8th handshake, out_valid first seen 15 cycles after the last load.
- Unsigned max, SIGNED=0: all A and B = 0xFF → every result is 520200 (8·255·255), with no wrap at ACC_WIDTH=19.
- Signed, SIGNED=1: all A = 0x80, B = 0x80 → every result is 131072. A[r][k]=-1, B=k+1 → every result is -36.
- Backpressure: drop out_ready for 5 cycles at out_idx=3 → out_data is held, and nothing is skipped or duplicated.
- acc_keep: run the identity test twice, second run with acc_keep=1 → results 2,4,…,16. A third run with acc_keep=0 → 1..8.
- Reset mid-CALC, at c=6: then do a full reload → in_ready=1 right after reset, and the results match a clean run with no stale accumulation.
